// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes, the PC register index, the multiply sequencer state type and a
// helper that picks the forwarding source for one Execute operand.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUOutM

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulState_t;

  // Memory beats Writeback; the PC is read from its own path and never bypassed.
  function automatic logic [1:0] fwdSelect(
    input logic [3:0] srcReg,
    input logic [3:0] dstM,
    input logic       wrM,
    input logic [3:0] dstW,
    input logic       wrW
  );
    if (srcReg == PC_REG)
      return FWD_RF;
    else if (wrM && (srcReg == dstM))
      return FWD_M;
    else if (wrW && (srcReg == dstW))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Multiply occupancy sequencer. Tracks a multiply held in Execute for
// MUL_LATENCY cycles: the start cycle (IDLE with MulStartE), MUL_LATENCY-2
// cycles in BUSY, then one DONE cycle in which the result is valid.
// With MUL_LATENCY==1 the FSM never leaves IDLE and MulDoneE mirrors MulStartE.
module mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic MulBusyE,
  output logic MulDoneE
);

  localparam bit         MULTI    = (MUL_LATENCY > 1);
  localparam int         LOAD_INT = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [3:0] LOAD_VAL = 4'(LOAD_INT);

  mulState_t  stateReg, stateNext;
  logic [3:0] cntReg, cntNext;

  // State and remaining-BUSY-cycle counter; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Next state: the counter holds BUSY cycles still to run, so BUSY exits once
  // the decremented count reaches zero. A two-cycle multiply skips BUSY.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (MulStartE && MULTI) begin
          if (LOAD_VAL == 4'd0) begin
            stateNext = DONE;
          end else begin
            stateNext = BUSY;
            cntNext   = LOAD_VAL;
          end
        end
      end
      BUSY: begin
        cntNext = cntReg - 4'd1;
        if (cntNext == 4'd0)
          stateNext = DONE;
      end
      DONE: begin
        // Same multiply is still in Execute here, so MulStartE is ignored.
        stateNext = IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs: the start cycle already counts as busy; everything is quiet in reset.
  always_comb begin
    MulBusyE = 1'b0;
    MulDoneE = 1'b0;
    if (!reset) begin
      case (stateReg)
        IDLE: begin
          MulBusyE = MulStartE & MULTI;
          MulDoneE = MulStartE & ~MULTI;
        end
        BUSY:    MulBusyE = 1'b1;
        DONE:    MulDoneE = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core: Execute operand
// forwarding, load-use stalls, control-flow flushes and multiply holds.
// Optional build macro HAZARD_PERF_EN adds saturating StallCount/FlushCount
// performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusyE,
  output logic       MulDoneE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  logic [3:0] srcE [2];
  logic [1:0] fwdRaw [2];
  logic       ldrStall;
  logic       pcPend;
  logic       mulBusy;
  logic       mulDone;

  assign srcE[0] = RA1E;
  assign srcE[1] = RA2E;

  // One forwarding selector per Execute source operand.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
      assign fwdRaw[gi] = fwdSelect(srcE[gi], WA3M, RegWriteM, WA3W, RegWriteW);
    end
  endgenerate

  // A load writing R15 is a branch and is handled by the PC path, not a stall.
  assign ldrStall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)) & (WA3E != PC_REG);
  assign pcPend   = PCSrcD | PCSrcE | PCSrcM;

  mul_seq #(
    .MUL_LATENCY(MUL_LATENCY)
  ) uMulSeq (
    .clk      (clk),
    .reset    (reset),
    .MulStartE(MulStartE),
    .MulBusyE (mulBusy),
    .MulDoneE (mulDone)
  );

  // Stall/flush equations; a held multiply keeps Execute intact, so it masks the
  // load-use bubble there. Reset drains every stage into bubbles.
  always_comb begin
    ForwardAE = fwdRaw[0];
    ForwardBE = fwdRaw[1];
    StallF    = ldrStall | pcPend | mulBusy;
    StallD    = ldrStall | mulBusy;
    StallE    = mulBusy;
    FlushD    = pcPend | PCSrcW | BranchTakenE;
    FlushE    = (ldrStall | BranchTakenE) & ~mulBusy;
    FlushM    = mulBusy;
    MulBusyE  = mulBusy;
    MulDoneE  = mulDone;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      MulBusyE  = 1'b0;
      MulDoneE  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCountReg;
  logic [31:0] flushCountReg;

  // Saturating event counters; the reset branch keeps reset-forced flushes out.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCountReg <= '0;
      flushCountReg <= '0;
    end else begin
      if (StallF && (stallCountReg != '1))
        stallCountReg <= stallCountReg + 32'd1;
      if ((FlushD || FlushE) && (flushCountReg != '1))
        flushCountReg <= flushCountReg + 32'd1;
    end
  end

  assign StallCount = stallCountReg;
  assign FlushCount = flushCountReg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a directed vector table, hand-written
// multiply / reset-abort / PC-travel sequences, then randomized cycles checked
// against a cycle-count reference model. Output bundle layout (12 bits):
// {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE}
module tb_hazard_unit;

  localparam int LAT = 4;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount;
  int          stallModel;
  int          flushModel;
`endif

  typedef struct packed {
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic [11:0] exp;
    string       name;
  } vec_t;

  int checkCnt;
  int passCnt;
  int mulPhase;   // cycles elapsed since the current multiply started; 0 = none

  hazard_unit #(
    .MUL_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RA1D        (RA1D),
    .RA2D        (RA2D),
    .RA1E        (RA1E),
    .RA2E        (RA2E),
    .WA3E        (WA3E),
    .WA3M        (WA3M),
    .WA3W        (WA3W),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .PCSrcD      (PCSrcD),
    .PCSrcE      (PCSrcE),
    .PCSrcM      (PCSrcM),
    .PCSrcW      (PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MulStartE   (MulStartE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .MulBusyE    (MulBusyE),
    .MulDoneE    (MulDoneE)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount  (StallCount),
    .FlushCount  (FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vin_t mkIn(input int ra1d, input int ra2d, input int ra1e, input int ra2e,
                                input int wa3e, input int wa3m, input int wa3w,
                                input bit rwm, input bit rww, input bit mem,
                                input bit pcd, input bit pce, input bit pcm, input bit pcw,
                                input bit br, input bit ms);
    vin_t v;
    v.RA1D = 4'(ra1d);  v.RA2D = 4'(ra2d);
    v.RA1E = 4'(ra1e);  v.RA2E = 4'(ra2e);
    v.WA3E = 4'(wa3e);  v.WA3M = 4'(wa3m);  v.WA3W = 4'(wa3w);
    v.RegWriteM = rwm;  v.RegWriteW = rww;  v.MemtoRegE = mem;
    v.PCSrcD = pcd;  v.PCSrcE = pce;  v.PCSrcM = pcm;  v.PCSrcW = pcw;
    v.BranchTakenE = br;  v.MulStartE = ms;
    return v;
  endfunction

  // Reference forwarding choice for one operand.
  function automatic logic [1:0] refFwd(input logic [3:0] ra, input logic [3:0] m, input logic rwm,
                                        input logic [3:0] w, input logic rww);
    if (ra == 4'd15) return 2'b00;
    if (rwm && ra == m) return 2'b10;
    if (rww && ra == w) return 2'b01;
    return 2'b00;
  endfunction

  // Reference outputs from the hazard rules plus the multiply cycle count.
  function automatic logic [11:0] refModel(input vin_t v, input logic rst);
    logic ldr, pend, busy, done;
    logic sF, sD, sE, fD, fE, fM;
    if (rst) return 12'h01C;
    ldr  = v.MemtoRegE && (v.WA3E != 4'd15) && (v.RA1D == v.WA3E || v.RA2D == v.WA3E);
    pend = v.PCSrcD || v.PCSrcE || v.PCSrcM;
    if (mulPhase == 0) begin
      busy = v.MulStartE && (LAT > 1);
      done = v.MulStartE && (LAT == 1);
    end else if (mulPhase < LAT - 1) begin
      busy = 1'b1;
      done = 1'b0;
    end else begin
      busy = 1'b0;
      done = 1'b1;
    end
    sF = ldr || pend || busy;
    sD = ldr || busy;
    sE = busy;
    fD = pend || v.PCSrcW || v.BranchTakenE;
    fE = (ldr || v.BranchTakenE) && !busy;
    fM = busy;
    return {refFwd(v.RA1E, v.WA3M, v.RegWriteM, v.WA3W, v.RegWriteW),
            refFwd(v.RA2E, v.WA3M, v.RegWriteM, v.WA3W, v.RegWriteW),
            sF, sD, sE, fD, fE, fM, busy, done};
  endfunction

  function automatic int pickReg();
    int k;
    k = int'($urandom_range(0, 4));
    return (k == 4) ? 15 : k;
  endfunction

  task automatic drive(input vin_t v, input logic rst);
    reset = rst;
    RA1D = v.RA1D;  RA2D = v.RA2D;  RA1E = v.RA1E;  RA2E = v.RA2E;
    WA3E = v.WA3E;  WA3M = v.WA3M;  WA3W = v.WA3W;
    RegWriteM = v.RegWriteM;  RegWriteW = v.RegWriteW;  MemtoRegE = v.MemtoRegE;
    PCSrcD = v.PCSrcD;  PCSrcE = v.PCSrcE;  PCSrcM = v.PCSrcM;  PCSrcW = v.PCSrcW;
    BranchTakenE = v.BranchTakenE;  MulStartE = v.MulStartE;
  endtask

  // One transaction: drive after the edge, compare at the falling edge, advance.
  task automatic apply(input vin_t v, input logic rst, input logic [11:0] exp, input string name);
    logic [11:0] act;
    drive(v, rst);
    @(negedge clk);
    act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE};
    checkCnt++;
    if (act === exp) begin
      passCnt++;
      $display("[%0t] %s rst=%0b out=%03h ok", $time, name, rst, act);
    end else begin
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
`ifdef HAZARD_PERF_EN
    if (rst) begin
      stallModel = 0;
      flushModel = 0;
    end else begin
      stallModel += int'(exp[7]);
      flushModel += int'(exp[4] | exp[3]);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];
  vin_t idleIn;
  vin_t v;
  logic r;

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    mulPhase = 0;
`ifdef HAZARD_PERF_EN
    stallModel = 0;
    flushModel = 0;
`endif
    idleIn = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //                ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwm rww mem pcd pce pcm pcw br ms
    vecs[0]  = '{mkIn(0,  0,  3,  0,  0,  3,  3,  1, 1, 0, 0, 0, 0, 0, 0, 0), 12'h800, "fwdMem"};
    vecs[1]  = '{mkIn(0,  0,  3,  0,  0,  3,  3,  0, 1, 0, 0, 0, 0, 0, 0, 0), 12'h400, "fwdWb"};
    vecs[2]  = '{mkIn(0,  0, 15,  0,  0, 15, 15,  1, 1, 0, 0, 0, 0, 0, 0, 0), 12'h000, "fwdR15"};
    vecs[3]  = '{mkIn(0,  0,  2,  7,  0,  7,  2,  1, 1, 0, 0, 0, 0, 0, 0, 0), 12'h600, "fwdBoth"};
    vecs[4]  = '{mkIn(1,  5,  0,  0,  5,  0,  0,  0, 0, 1, 0, 0, 0, 0, 0, 0), 12'h0C8, "ldrUse"};
    vecs[5]  = '{mkIn(15, 0,  0,  0, 15,  0,  0,  0, 0, 1, 0, 0, 0, 0, 0, 0), 12'h000, "ldrR15"};
    vecs[6]  = '{mkIn(5,  0,  0,  0,  5,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0), 12'h000, "noLoad"};
    vecs[7]  = '{mkIn(0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0), 12'h090, "pcSrcD"};
    vecs[8]  = '{mkIn(0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0), 12'h010, "pcSrcW"};
    vecs[9]  = '{mkIn(0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0), 12'h018, "branch"};
    vecs[10] = '{mkIn(4,  0,  0,  0,  4,  0,  0,  0, 0, 1, 0, 0, 0, 0, 1, 0), 12'h0D8, "ldrBranch"};

    // Reset with live hazards on the inputs: everything drains to bubbles.
    drive(idleIn, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    apply(mkIn(3, 3, 3, 3, 3, 3, 3, 1, 1, 1, 1, 0, 0, 0, 0, 1), 1'b1, 12'h01C, "resetState");

    for (int i = 0; i < 11; i++)
      apply(vecs[i].in, 1'b0, vecs[i].exp, vecs[i].name);

    // Two back-to-back multiplies with MulStartE held throughout.
    for (int c = 0; c < 2 * LAT; c++)
      apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0,
            ((c % LAT) == LAT - 1) ? 12'h001 : 12'h0E6, "mulSeq");
    apply(idleIn, 1'b0, 12'h000, "mulIdle");

    // Reset in the first BUSY cycle aborts without a done pulse.
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 12'h0E6, "abortStart");
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 12'h01C, "abortReset");
    apply(idleIn, 1'b0, 12'h000, "abortNoDone");
    for (int c = 0; c < LAT; c++)
      apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0,
            (c == LAT - 1) ? 12'h001 : 12'h0E6, "mulAfterAbort");
    apply(idleIn, 1'b0, 12'h000, "mulIdle2");

    // A PC write travelling D -> E -> M -> W.
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, 12'h090, "pcTravelD");
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, 12'h090, "pcTravelE");
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0, 12'h090, "pcTravelM");
    apply(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 12'h010, "pcTravelW");

    // Randomized cycles against the reference model, starting from idle.
    mulPhase = 0;
    for (int n = 0; n < 300; n++) begin
      bit br, ms;
      r  = ($urandom_range(0, 39) == 0);
      br = ($urandom_range(0, 7) == 0);
      ms = !br && ($urandom_range(0, 3) == 0);
      v  = mkIn(pickReg(), pickReg(), pickReg(), pickReg(), pickReg(), pickReg(), pickReg(),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), br, ms);
      apply(v, r, refModel(v, r), "rand");
      if (r)
        mulPhase = 0;
      else if (mulPhase == 0)
        mulPhase = (ms && LAT > 1) ? 1 : 0;
      else if (mulPhase == LAT - 1)
        mulPhase = 0;
      else
        mulPhase++;
    end

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    checkCnt++;
    if (StallCount === 32'(stallModel)) passCnt++;
    else $display("FAIL stallCount: got %0d expected %0d", StallCount, stallModel);
    checkCnt++;
    if (FlushCount === 32'(flushModel)) passCnt++;
    else $display("FAIL flushCount: got %0d expected %0d", FlushCount, flushModel);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
